// File: rtl/addsub_exerciser_if.sv
// Operand/result bus between the exerciser and a WIDTH-bit adder/subtractor.
// The master drives the operands, and the slave returns sum, carry and overflow
// combinationally.
interface addsub_exerciser_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             m;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (output num1, output num2, output m,
                  input  sum,  input  c_out, input  overflow);
  modport slave  (input  num1, input  num2, input  m,
                  output sum,  output c_out, output overflow);
endinterface

// File: rtl/addsub_exerciser.sv
// addsub_exerciser: sweeps every {m, num1, num2} vector into an adder/subtractor.
// Each result is checked against a built-in golden model, and the mismatches are counted.
// Optional feature macro: ADDSUB_EXERCISER_STOP_ON_ERR_EN makes the sweep stop at the first
// mismatch and hold that vector on the bus.
//
// Bus protocol (there is no valid/ready): the operands change only on the edge
// that enters APPLY. They then stay stable for SETTLE cycles, and the results are
// sampled on the single CHECK cycle that follows. The DUT therefore has SETTLE+1
// cycles to settle.
module addsub_exerciser #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  addsub_exerciser_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [1:0]           state_dbg
);

  localparam int IW = 2 * WIDTH + 1;
  localparam int EW = 2 * WIDTH + 2;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW-1:0] IDX_MAX  = {IW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   settle_cnt;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full_sum;
  logic [WIDTH-1:0] low_sum;
  logic             exp_c;
  logic             exp_ovf;
  logic             mismatch;
  logic [EW-1:0]    err_next;

  // The operands come straight from the index register, so they are registered and
  // change only when idx changes.
  assign bus.m     = idx[IW-1];
  assign bus.num1  = idx[IW-2:WIDTH];
  assign bus.num2  = idx[WIDTH-1:0];
  assign state_dbg = state;

  // Golden model: a two's-complement add/subtract. Overflow is the carry into the MSB
  // XOR the carry out of the MSB.
  always_comb begin
    b_eff    = bus.m ? ~bus.num2 : bus.num2;
    full_sum = {1'b0, bus.num1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.m};
    low_sum  = {1'b0, bus.num1[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
             + {{(WIDTH-1){1'b0}}, bus.m};
    exp_c    = full_sum[WIDTH];
    exp_ovf  = low_sum[WIDTH-1] ^ full_sum[WIDTH];
    mismatch = (bus.sum != full_sum[WIDTH-1:0]) || (bus.c_out != exp_c)
            || (bus.overflow != exp_ovf);
    err_next = err_count + {{(EW-1){1'b0}}, mismatch};
  end

  // Sweep sequencer: IDLE/DONE wait for start, APPLY holds the operands, and CHECK
  // scores the vector and advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            idx        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        APPLY: begin
          if (settle_cnt == CNT_LAST) begin
            state      <= CHECK;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          err_count <= err_next;
`ifdef ADDSUB_EXERCISER_STOP_ON_ERR_EN
          if (mismatch || idx == IDX_MAX) begin
`else
          if (idx == IDX_MAX) begin
`endif
            // Leave idx alone so that the last (or failing) vector stays on the bus.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= APPLY;
            idx   <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_exerciser.sv
// Bench for addsub_exerciser. A behavioural 4-bit adder/subtractor sits on the bus,
// and its overflow output can be forced to stuck-at-0 as a fault.
module tb_addsub_exerciser;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic pass;
  logic [2*WIDTH+1:0] err_count;
  logic [1:0] state_dbg;
  logic stuck_ovf;

  int checks;
  int errors;

  addsub_exerciser_if #(.WIDTH(WIDTH)) bus_if ();

  addsub_exerciser #(.WIDTH(WIDTH), .SETTLE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus_if),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .state_dbg (state_dbg)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder/subtractor. Overflow uses the sign-rule formulation.
  logic [WIDTH-1:0] tb_b;
  logic [WIDTH:0]   tb_r;
  logic             tb_ovf;
  always_comb begin
    tb_b   = bus_if.m ? ~bus_if.num2 : bus_if.num2;
    tb_r   = {1'b0, bus_if.num1} + {1'b0, tb_b} + {4'b0000, bus_if.m};
    tb_ovf = (bus_if.num1[WIDTH-1] == tb_b[WIDTH-1]) && (tb_r[WIDTH-1] != bus_if.num1[WIDTH-1]);
    bus_if.sum      = tb_r[WIDTH-1:0];
    bus_if.c_out    = tb_r[WIDTH];
    bus_if.overflow = stuck_ovf ? 1'b0 : tb_ovf;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Starts a sweep and runs it to done.
  // - hold_until: the cycle before whose edge start is released.
  // - pulse_at: the cycle on which start is pulsed again mid-sweep (0 = never).
  // - spot: enables the T2 spot checks.
  task automatic run_sweep(input int pulse_at, input int hold_until, input bit spot,
                           output int cycles);
    start = 1'b1;
    @(posedge clk); #1;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("err_cleared", err_count, 0);
    cycles = -1;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      if (cyc == hold_until) start = 1'b0;
      if (cyc == pulse_at) start = 1'b1;
      else if (pulse_at != 0 && cyc == pulse_at + 1) start = 1'b0;
      @(posedge clk); #1;
      if (spot && cyc == 159) begin
        check("spot1_vec", {bus_if.m, bus_if.num1, bus_if.num2}, {1'b0, 4'd3, 4'd5});
        check("spot1_sum", bus_if.sum, 8);
        check("spot1_c", bus_if.c_out, 0);
        check("spot1_ovf", bus_if.overflow, 1);
      end
      if (spot && cyc == 1107) begin
        check("spot2_vec", {bus_if.m, bus_if.num1, bus_if.num2}, {1'b1, 4'd7, 4'd1});
        check("spot2_res", {bus_if.sum, bus_if.c_out, bus_if.overflow}, {4'd6, 1'b1, 1'b0});
      end
      if (spot && cyc == 1155) begin
        check("spot3_vec", {bus_if.m, bus_if.num1, bus_if.num2}, {1'b1, 4'd8, 4'd1});
        check("spot3_res", {bus_if.sum, bus_if.c_out, bus_if.overflow}, {4'd7, 1'b1, 1'b1});
      end
      if (done) begin
        cycles = cyc;
        break;
      end
    end
    start = 1'b0;
    if (cycles < 0) check("sweep_timeout", 0, 1);
  endtask

  int cyc_n;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stuck_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ops", {bus_if.m, bus_if.num1, bus_if.num2}, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 + T2 + T6a: clean sweep, with a start pulse during APPLY that must be ignored.
    run_sweep(10, 1, 1'b1, cyc_n);
    check("t1_cycles", cyc_n, 1536);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_state", state_dbg, 3);
    check("t1_last_vec", {bus_if.m, bus_if.num1, bus_if.num2}, 9'h1ff);

    // T3/T4: DUT overflow output stuck-at-0.
    stuck_ovf = 1'b1;
    run_sweep(0, 1, 1'b0, cyc_n);
    check("t3_done", done, 1);
    check("t3_pass", pass, 0);
`ifdef ADDSUB_EXERCISER_STOP_ON_ERR_EN
    check("t4_err", err_count, 1);
    check("t4_vec", {bus_if.m, bus_if.num1, bus_if.num2}, {1'b0, 4'd1, 4'd7});
`else
    check("t3_err", err_count, 128);
    check("t3_cycles", cyc_n, 1536);
`endif

    // T6b: start held high at DONE restarts the sweep and clears err_count.
    stuck_ovf = 1'b0;
    run_sweep(0, 20, 1'b0, cyc_n);
    check("t6_cycles", cyc_n, 1536);
    check("t6_pass", pass, 1);
    check("t6_err", err_count, 0);

    // T5: asynchronous reset at vector 100 (m=0, num1=6, num2=4).
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("t5_vec100", {bus_if.m, bus_if.num1, bus_if.num2}, {1'b0, 4'd6, 4'd4});
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_pass", pass, 0);
    check("t5_err", err_count, 0);
    check("t5_ops", {bus_if.m, bus_if.num1, bus_if.num2}, 0);
    check("t5_state", state_dbg, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_sweep(0, 1, 1'b0, cyc_n);
    check("t5_resweep_cycles", cyc_n, 1536);
    check("t5_resweep_pass", pass, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
